// File: rtl/reset_sequencer.sv
// Staged system reset sequencer: hold, ordered per-domain release, grace window,
// and fault counting with lockout after repeated watchdog errors.
module reset_sequencer #(
    parameter int Hold_Cycles        = 16,
    parameter int Stages             = 3,
    parameter int Stage_Delay_Cycles = 8,
    parameter int Grace_Cycles       = 64,
    parameter int Max_Faults         = 3
) (
    input  logic                               ipClk,
    input  logic                               ipReset,
    input  logic                               ipError,
    input  logic                               ipManualReset,
    output logic [Stages-1:0]                  opReset,
    output logic                               opReady,
    output logic                               opLockout,
    output logic [$clog2(Max_Faults+1)-1:0]    opFaults
);

    localparam int HoldSd = (Hold_Cycles > Stage_Delay_Cycles) ?
                            Hold_Cycles : Stage_Delay_Cycles;
    localparam int MaxCnt = (HoldSd > Grace_Cycles) ? HoldSd : Grace_Cycles;
    localparam int CW     = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
    localparam int FW     = $clog2(Max_Faults + 1);

    localparam logic [CW-1:0] HoldLd  = CW'(Hold_Cycles - 1);
    localparam logic [CW-1:0] DelayLd = CW'(Stage_Delay_Cycles - 1);
    localparam logic [CW-1:0] GraceLd = CW'(Grace_Cycles - 1);
    localparam logic [FW-1:0] FaultMax = FW'(Max_Faults);

    typedef enum logic [2:0] {
        HOLD,
        RELEASE,
        GRACE,
        RUN,
        LOCKOUT
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [Stages-1:0] rst_q, rst_d;
    logic              ready_q, ready_d;
    logic              lock_q, lock_d;
    logic [FW-1:0]     faults_q, faults_d;
    logic [Stages-1:0] rst_shift;
    logic [FW-1:0]     faults_inc;

    // Lowest still-asserted domain is released first, so a left shift
    // clears exactly the next bit in order.
    assign rst_shift  = rst_q << 1;
    assign faults_inc = (faults_q == FaultMax) ? faults_q : faults_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rst_d    = rst_q;
        ready_d  = ready_q;
        lock_d   = lock_q;
        faults_d = faults_q;
        if (ipManualReset) begin
            state_d  = HOLD;
            cnt_d    = HoldLd;
            rst_d    = '1;
            ready_d  = 1'b0;
            lock_d   = 1'b0;
            faults_d = '0;
        end else begin
            unique case (state_q)
                HOLD, RELEASE: begin
                    if (cnt_q == '0) begin
                        rst_d = rst_shift;
                        if (rst_shift == '0) begin
                            state_d = GRACE;
                            cnt_d   = GraceLd;
                        end else begin
                            state_d = RELEASE;
                            cnt_d   = DelayLd;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                GRACE: begin
                    if (cnt_q == '0) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                RUN: begin
                    if (ipError) begin
                        faults_d = faults_inc;
                        rst_d    = '1;
                        ready_d  = 1'b0;
                        if (faults_inc == FaultMax) begin
                            state_d = LOCKOUT;
                            lock_d  = 1'b1;
                        end else begin
                            state_d = HOLD;
                            cnt_d   = HoldLd;
                        end
                    end
                end
                LOCKOUT: begin
                    rst_d = '1;
                end
                default: begin
                    state_d = HOLD;
                    cnt_d   = HoldLd;
                    rst_d   = '1;
                end
            endcase
        end
    end

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state_q  <= HOLD;
            cnt_q    <= HoldLd;
            rst_q    <= '1;
            ready_q  <= 1'b0;
            lock_q   <= 1'b0;
            faults_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rst_q    <= rst_d;
            ready_q  <= ready_d;
            lock_q   <= lock_d;
            faults_q <= faults_d;
        end
    end

    assign opReset   = rst_q;
    assign opReady   = ready_q;
    assign opLockout = lock_q;
    assign opFaults  = faults_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with Hold=4, Stages=3, Stage_Delay=2,
// Grace=5, Max_Faults=3.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       err = 1'b0;
    logic       man = 1'b0;
    logic [2:0] op_reset;
    logic       op_ready;
    logic       op_lock;
    logic [1:0] op_faults;

    int checks = 0;
    int errors = 0;

    reset_sequencer #(
        .Hold_Cycles(4),
        .Stages(3),
        .Stage_Delay_Cycles(2),
        .Grace_Cycles(5),
        .Max_Faults(3)
    ) dut (
        .ipClk(clk),
        .ipReset(rst),
        .ipError(err),
        .ipManualReset(man),
        .opReset(op_reset),
        .opReady(op_ready),
        .opLockout(op_lock),
        .opFaults(op_faults)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        err = 1'b0;
        man = 1'b0;
        repeat (3) tick();
        checks++;
        if (op_reset !== 3'b111 || op_ready !== 1'b0 ||
            op_lock !== 1'b0 || op_faults !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got rst=%b rdy=%b lk=%b f=%0d want 111 0 0 0",
                     op_reset, op_ready, op_lock, op_faults);
        end
    endtask

    task automatic test_reset_exit();
        logic [2:0] exp_r;
        logic       exp_y;
        rst = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            tick();
            exp_r = (e < 4) ? 3'b111 : (e < 6) ? 3'b110 :
                    (e < 8) ? 3'b100 : 3'b000;
            exp_y = (e >= 13);
            checks++;
            if (op_reset !== exp_r || op_ready !== exp_y) begin
                errors++;
                $display("FAIL reset_exit e%0d: got rst=%b rdy=%b want %b %b",
                         e, op_reset, op_ready, exp_r, exp_y);
            end
        end
        checks++;
        if (op_faults !== 2'd0) begin
            errors++;
            $display("FAIL reset_exit_faults: got %0d want 0", op_faults);
        end
    endtask

    task automatic test_grace();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            err = (e >= 9 && e <= 13);
            tick();
        end
        err = 1'b0;
        checks++;
        if (op_ready !== 1'b1 || op_faults !== 2'd0 || op_reset !== 3'b000) begin
            errors++;
            $display("FAIL grace_mask: got rdy=%b f=%0d rst=%b want 1 0 000",
                     op_ready, op_faults, op_reset);
        end
    endtask

    task automatic test_single_fault();
        logic [2:0] exp_r;
        logic       exp_y;
        err = 1'b1;
        tick();
        err = 1'b0;
        checks++;
        if (op_reset !== 3'b111 || op_ready !== 1'b0 || op_faults !== 2'd1) begin
            errors++;
            $display("FAIL fault_edge: got rst=%b rdy=%b f=%0d want 111 0 1",
                     op_reset, op_ready, op_faults);
        end
        for (int e = 1; e <= 13; e++) begin
            tick();
            exp_r = (e < 4) ? 3'b111 : (e < 6) ? 3'b110 :
                    (e < 8) ? 3'b100 : 3'b000;
            exp_y = (e >= 13);
            checks++;
            if (op_reset !== exp_r || op_ready !== exp_y) begin
                errors++;
                $display("FAIL fault_rerun e%0d: got rst=%b rdy=%b want %b %b",
                         e, op_reset, op_ready, exp_r, exp_y);
            end
        end
        checks++;
        if (op_faults !== 2'd1) begin
            errors++;
            $display("FAIL fault_history: got %0d want 1", op_faults);
        end
    endtask

    task automatic test_lockout();
        err = 1'b1;
        tick();
        err = 1'b0;
        checks++;
        if (op_faults !== 2'd2 || op_lock !== 1'b0 || op_reset !== 3'b111) begin
            errors++;
            $display("FAIL fault2: got f=%0d lk=%b rst=%b want 2 0 111",
                     op_faults, op_lock, op_reset);
        end
        repeat (13) tick();
        checks++;
        if (op_ready !== 1'b1) begin
            errors++;
            $display("FAIL fault2_run: got rdy=%b want 1", op_ready);
        end
        err = 1'b1;
        tick();
        err = 1'b0;
        checks++;
        if (op_lock !== 1'b1 || op_faults !== 2'd3 ||
            op_reset !== 3'b111 || op_ready !== 1'b0) begin
            errors++;
            $display("FAIL lockout_enter: got lk=%b f=%0d rst=%b rdy=%b want 1 3 111 0",
                     op_lock, op_faults, op_reset, op_ready);
        end
        for (int e = 1; e <= 100; e++) begin
            tick();
            checks++;
            if (op_lock !== 1'b1 || op_faults !== 2'd3 ||
                op_reset !== 3'b111 || op_ready !== 1'b0) begin
                errors++;
                $display("FAIL lockout_hold e%0d: got lk=%b f=%0d rst=%b rdy=%b",
                         e, op_lock, op_faults, op_reset, op_ready);
            end
        end
    endtask

    task automatic test_manual_exit();
        logic [2:0] exp_r;
        logic       exp_y;
        man = 1'b1;
        repeat (2) tick();
        checks++;
        if (op_lock !== 1'b0 || op_faults !== 2'd0 || op_reset !== 3'b111) begin
            errors++;
            $display("FAIL manual_clear: got lk=%b f=%0d rst=%b want 0 0 111",
                     op_lock, op_faults, op_reset);
        end
        man = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            tick();
            exp_r = (e < 4) ? 3'b111 : (e < 6) ? 3'b110 :
                    (e < 8) ? 3'b100 : 3'b000;
            exp_y = (e >= 13);
            checks++;
            if (op_reset !== exp_r || op_ready !== exp_y) begin
                errors++;
                $display("FAIL manual_exit e%0d: got rst=%b rdy=%b want %b %b",
                         e, op_reset, op_ready, exp_r, exp_y);
            end
        end
    endtask

    task automatic test_priority();
        logic [2:0] exp_r;
        logic       exp_y;
        err = 1'b1;
        man = 1'b1;
        tick();
        err = 1'b0;
        man = 1'b0;
        checks++;
        if (op_faults !== 2'd0 || op_reset !== 3'b111 ||
            op_ready !== 1'b0 || op_lock !== 1'b0) begin
            errors++;
            $display("FAIL prio_manual: got f=%0d rst=%b rdy=%b lk=%b want 0 111 0 0",
                     op_faults, op_reset, op_ready, op_lock);
        end
        repeat (5) tick();
        checks++;
        if (op_reset !== 3'b110) begin
            errors++;
            $display("FAIL prio_mid_release: got rst=%b want 110", op_reset);
        end
        rst = 1'b1;
        man = 1'b1;
        tick();
        rst = 1'b0;
        man = 1'b0;
        checks++;
        if (op_reset !== 3'b111 || op_ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_reset: got rst=%b rdy=%b want 111 0",
                     op_reset, op_ready);
        end
        for (int e = 1; e <= 13; e++) begin
            tick();
            exp_r = (e < 4) ? 3'b111 : (e < 6) ? 3'b110 :
                    (e < 8) ? 3'b100 : 3'b000;
            exp_y = (e >= 13);
            checks++;
            if (op_reset !== exp_r || op_ready !== exp_y) begin
                errors++;
                $display("FAIL prio_restart e%0d: got rst=%b rdy=%b want %b %b",
                         e, op_reset, op_ready, exp_r, exp_y);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_exit();
        test_grace();
        test_single_fault();
        test_lockout();
        test_manual_exit();
        test_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
